mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter that multiplexes the I-cache and D-cache line buses onto one
// physical memory port, alternating owners on ties and inserting a turnaround cycle.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128,
  parameter int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_dat_w,
  input  logic [SEL_W-1:0]  i_sel,
  output logic              i_ack,
  output logic              i_retry,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_dat_w,
  input  logic [SEL_W-1:0]  d_sel,
  output logic              d_ack,
  output logic              d_retry,
  output logic [DATA_W-1:0] rq_dat_r,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_dat_w,
  output logic [SEL_W-1:0]  m_sel,
  input  logic              m_ack,
  input  logic              m_retry,
  input  logic [DATA_W-1:0] m_dat_r,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, TURN} state_e;

  state_e state_q, state_d;
  logic   lastD_q, lastD_d;
  logic   iReq, dReq, done;

  assign iReq = i_cyc & i_stb;
  assign dReq = d_cyc & d_stb;
  assign done = m_ack & ~m_retry;

  // lastD_q resets to D so that the I-cache wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lastD_q <= 1'b1;
    end else begin
      state_q <= state_d;
      lastD_q <= lastD_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lastD_d = lastD_q;
    unique case (state_q)
      IDLE: begin
        if (iReq && (!dReq || lastD_q)) begin
          state_d = GNT_I;
          lastD_d = 1'b0;
        end else if (dReq) begin
          state_d = GNT_D;
          lastD_d = 1'b1;
        end
      end
      // An owner dropping cyc ends the tenure even while memory is retrying.
      GNT_I: if (!i_cyc || done) state_d = TURN;
      GNT_D: if (!d_cyc || done) state_d = TURN;
      TURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_dat_w = '0;
    m_sel   = '0;
    i_ack   = 1'b0;
    i_retry = 1'b0;
    d_ack   = 1'b0;
    d_retry = 1'b0;
    unique case (state_q)
      GNT_I: begin
        m_cyc   = i_cyc;
        m_stb   = i_stb;
        m_we    = i_we;
        m_adr   = i_adr;
        m_dat_w = i_dat_w;
        m_sel   = i_sel;
        i_ack   = done;
        i_retry = m_retry;
      end
      GNT_D: begin
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_adr   = d_adr;
        m_dat_w = d_dat_w;
        m_sel   = d_sel;
        d_ack   = done;
        d_retry = m_retry;
      end
      default: ;
    endcase
  end

  assign grant    = {state_q == GNT_D, state_q == GNT_I};
  assign rq_dat_r = m_dat_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// traffic, all compared each cycle against an owner/turnaround reference model.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;
  localparam int SEL_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
  logic [ADDR_W-1:0] i_adr, d_adr;
  logic [DATA_W-1:0] i_dat_w, d_dat_w;
  logic [SEL_W-1:0]  i_sel, d_sel;
  logic              i_ack, i_retry, d_ack, d_retry;
  logic [DATA_W-1:0] rq_dat_r;
  logic              m_cyc, m_stb, m_we;
  logic [ADDR_W-1:0] m_adr;
  logic [DATA_W-1:0] m_dat_w;
  logic [SEL_W-1:0]  m_sel;
  logic              m_ack, m_retry;
  logic [DATA_W-1:0] m_dat_r;
  logic [1:0]        grant;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w),
    .i_sel(i_sel), .i_ack(i_ack), .i_retry(i_retry),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_w(d_dat_w),
    .d_sel(d_sel), .d_ack(d_ack), .d_retry(d_retry),
    .rq_dat_r(rq_dat_r),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_sel(m_sel), .m_ack(m_ack), .m_retry(m_retry), .m_dat_r(m_dat_r),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the bus (0 none, 1 I, 2 D), whether this is the
  // turnaround cycle, and whether D was the most recent owner.
  int owner, nOwner;
  bit inTurn, nTurn;
  bit lastWasD, nLastWasD;
  int iAckSeen, dAckSeen, dRetrySeen;

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    owner = 0; inTurn = 0; lastWasD = 1;
  endtask

  task automatic checkOutput();
    logic              eCyc, eStb, eWe;
    logic [ADDR_W-1:0] eAdr;
    logic [DATA_W-1:0] eDat;
    logic [SEL_W-1:0]  eSel;
    logic              xfer;
    xfer = m_ack && !m_retry;
    eCyc = 0; eStb = 0; eWe = 0; eAdr = '0; eDat = '0; eSel = '0;
    if (owner == 1) begin
      eCyc = i_cyc; eStb = i_stb; eWe = i_we; eAdr = i_adr; eDat = i_dat_w; eSel = i_sel;
    end else if (owner == 2) begin
      eCyc = d_cyc; eStb = d_stb; eWe = d_we; eAdr = d_adr; eDat = d_dat_w; eSel = d_sel;
    end
    checkVal("grant", 128'(grant), owner == 1 ? 128'd1 : owner == 2 ? 128'd2 : 128'd0);
    checkVal("m_cyc", 128'(m_cyc), 128'(eCyc));
    checkVal("m_stb", 128'(m_stb), 128'(eStb));
    checkVal("m_we", 128'(m_we), 128'(eWe));
    checkVal("m_adr", 128'(m_adr), 128'(eAdr));
    checkVal("m_dat_w", m_dat_w, eDat);
    checkVal("m_sel", 128'(m_sel), 128'(eSel));
    checkVal("i_ack", 128'(i_ack), 128'(owner == 1 && xfer));
    checkVal("d_ack", 128'(d_ack), 128'(owner == 2 && xfer));
    checkVal("i_retry", 128'(i_retry), 128'(owner == 1 && m_retry));
    checkVal("d_retry", 128'(d_retry), 128'(owner == 2 && m_retry));
    checkVal("rq_dat_r", rq_dat_r, m_dat_r);
    if (i_ack) iAckSeen++;
    if (d_ack) dAckSeen++;
    if (d_retry) dRetrySeen++;
  endtask

  task automatic modelNext();
    bit iP, dP, ownCyc;
    nOwner = owner; nTurn = 0; nLastWasD = lastWasD;
    iP = i_cyc && i_stb;
    dP = d_cyc && d_stb;
    if (inTurn) begin
      nOwner = 0;
    end else if (owner == 0) begin
      if (iP && dP) begin
        nOwner = lastWasD ? 1 : 2;
      end else if (iP) begin
        nOwner = 1;
      end else if (dP) begin
        nOwner = 2;
      end
      if (nOwner != 0) nLastWasD = (nOwner == 2);
    end else begin
      ownCyc = (owner == 1) ? i_cyc : d_cyc;
      if (!ownCyc || (m_ack && !m_retry)) begin
        nOwner = 0;
        nTurn = 1;
      end
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    checkOutput();
    modelNext();
    @(posedge clk);
    #1;
    owner = nOwner; inTurn = nTurn; lastWasD = nLastWasD;
  endtask

  // Reset is asserted between edges to show it acts without a clock.
  task automatic pulseReset();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    checkVal("rst_m_cyc", 128'(m_cyc), 128'd0);
    checkVal("rst_grant", 128'(grant), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic setIdle();
    i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_w = '0; i_sel = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_w = '0; d_sel = '0;
    m_ack = 0; m_retry = 0; m_dat_r = '0;
  endtask

  task automatic applyStimulus();
    i_cyc = ($urandom_range(0, 3) != 0);
    i_stb = ($urandom_range(0, 3) != 0);
    i_we = 1'($urandom);
    i_adr = 16'($urandom);
    i_dat_w = {$urandom, $urandom, $urandom, $urandom};
    i_sel = 16'($urandom);
    d_cyc = ($urandom_range(0, 3) != 0);
    d_stb = ($urandom_range(0, 3) != 0);
    d_we = 1'($urandom);
    d_adr = 16'($urandom);
    d_dat_w = {$urandom, $urandom, $urandom, $urandom};
    d_sel = 16'($urandom);
    m_ack = ($urandom_range(0, 2) == 0);
    m_retry = ($urandom_range(0, 4) == 0);
    m_dat_r = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    setIdle();
    modelReset();
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single I-cache fill at 0x1230 with a three-cycle memory response.
    iAckSeen = 0; dAckSeen = 0;
    i_cyc = 1; i_stb = 1; i_adr = 16'h1230; i_sel = 16'hFFFF;
    m_dat_r = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    runCycle();
    checkVal("r037_grant", 128'(grant), 128'd1);
    checkVal("r037_madr", 128'(m_adr), 128'h1230);
    runCycle();
    runCycle();
    m_ack = 1;
    runCycle();
    m_ack = 0; i_cyc = 0; i_stb = 0;
    checkVal("r037_turn", 128'(grant), 128'd0);
    runCycle();
    runCycle();
    checkVal("r037_iack", 128'(iAckSeen), 128'd1);
    checkVal("r037_dack", 128'(dAckSeen), 128'd0);

    // Both request from reset: I first, then D after the turnaround.
    pulseReset();
    i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
    runCycle();
    checkVal("r038_g0", 128'(grant), 128'd1);
    m_ack = 1;
    runCycle();
    m_ack = 0;
    checkVal("r038_g1", 128'(grant), 128'd0);
    runCycle();
    runCycle();
    checkVal("r038_g2", 128'(grant), 128'd2);

    // D owns; memory retries with ack for two cycles, then acks cleanly.
    i_cyc = 0; i_stb = 0;
    dAckSeen = 0; dRetrySeen = 0;
    m_retry = 1; m_ack = 1;
    runCycle();
    runCycle();
    checkVal("r039_hold", 128'(grant), 128'd2);
    m_retry = 0;
    runCycle();
    m_ack = 0; d_cyc = 0; d_stb = 0;
    checkVal("r039_dretry", 128'(dRetrySeen), 128'd2);
    checkVal("r039_dack", 128'(dAckSeen), 128'd1);
    runCycle();
    runCycle();

    // D write-back with full selects while I requests continuously.
    d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 16'hFFFF; d_adr = 16'h4440;
    d_dat_w = {$urandom, $urandom, $urandom, $urandom};
    runCycle();
    i_cyc = 1; i_stb = 1;
    iAckSeen = 0;
    checkVal("r040_mwe", 128'(m_we), 128'd1);
    runCycle();
    runCycle();
    m_ack = 1;
    runCycle();
    m_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    checkVal("r040_iack", 128'(iAckSeen), 128'd0);
    runCycle();
    runCycle();
    checkVal("r040_igrant", 128'(grant), 128'd1);

    // Reset during an I tenure with no ack, then a tie goes back to I.
    runCycle();
    pulseReset();
    d_cyc = 1; d_stb = 1;
    runCycle();
    checkVal("r041_grant", 128'(grant), 128'd1);

    // I aborts by dropping cyc; D is granted after the turnaround.
    iAckSeen = 0;
    i_cyc = 0; i_stb = 0;
    runCycle();
    checkVal("r042_turn", 128'(grant), 128'd0);
    runCycle();
    runCycle();
    checkVal("r042_dgrant", 128'(grant), 128'd2);
    checkVal("r042_iack", 128'(iAckSeen), 128'd0);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      applyStimulus();
      runCycle();
      if ($urandom_range(0, 99) == 0) pulseReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
